// File: rtl/ws2812_rx_if.sv
// Pixel-side bundle of the WS2812B receiver. The decoder drives everything
// here (master); the pixel consumer and any checkers observe it (slave).
//
// Strobe semantics: pixel_valid, frame_done and err are one-cycle strobes with
// no ready/backpressure path. pixel_data and pixel_index are meaningful in the
// cycle pixel_valid is high and are held until the next pixel completes.
// pixel_count is meaningful in the cycle frame_done is high and is held until
// the next frame_done. state mirrors the decoder FSM for debug visibility.
interface ws2812_rx_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        err;
  logic        busy;
  logic [1:0]  state;

  modport master (
    output pixel_data, pixel_valid, pixel_index, frame_done,
           pixel_count, err, busy, state
  );

  modport slave (
    input pixel_data, pixel_valid, pixel_index, frame_done,
          pixel_count, err, busy, state
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812B single-wire receiver: synchronises din, measures each high pulse,
// decodes bits by pulse width, assembles 24-bit pixels and ends a frame on a
// long low (latch) gap. Any protocol error drops back to SYNC, which waits for
// a full latch gap before decoding resumes.
module ws2812_rx #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int MIN_HIGH     = 2,
  parameter int THRESH       = 8,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 600,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  ws2812_rx_if.master    px
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RC_C   = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] MINH_C = CW'(MIN_HIGH);
  localparam logic [CW-1:0] TH_C   = CW'(THRESH);
  localparam logic [CW-1:0] MAXH_C = CW'(MAX_HIGH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  // The pulse-width windows must be ordered and fit the shared counter width.
  if (CLK_HZ <= 0 || MIN_HIGH < 1 || THRESH <= MIN_HIGH ||
      MAX_HIGH < THRESH || MAX_HIGH >= RESET_CYCLES) begin : g_bad_params
    $error("ws2812_rx: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            sync1, din_s, din_d;
  logic            rise, fall;
  logic [CW-1:0]   hcnt, hcnt_n;
  logic [CW-1:0]   lcnt, lcnt_n;
  logic [4:0]      bitcnt;
  logic [23:0]     shreg;
  logic [7:0]      idx;
  logic            shift_en, bit_val, drop, frame_end, err_n;

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;
  assign px.state = state;

  // Two-flop synchroniser for the asynchronous line plus an edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      sync1 <= din;
      din_s <= sync1;
      din_d <= din_s;
    end
  end

  // FSM state and pulse/gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      hcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      lcnt  <= lcnt_n;
    end
  end

  // Next-state logic: pulse classification, latch-gap detection and errors.
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    lcnt_n    = lcnt;
    shift_en  = 1'b0;
    bit_val   = 1'b0;
    drop      = 1'b0;
    frame_end = 1'b0;
    err_n     = 1'b0;
    case (state)
      SYNC: begin
        if (din_s) begin
          lcnt_n = '0;
        end else if (lcnt == RC_C) begin
          state_n = IDLE;
        end else begin
          lcnt_n = lcnt + ONE_C;
        end
      end
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          hcnt_n  = ONE_C;
        end
      end
      HIGH: begin
        // Over-long pulse is judged before the fall so MAX_HIGH+1 never decodes.
        if (hcnt > MAXH_C) begin
          err_n   = 1'b1;
          drop    = 1'b1;
          state_n = SYNC;
          lcnt_n  = '0;
        end else if (fall) begin
          if (hcnt < MINH_C) begin
            err_n   = 1'b1;
            drop    = 1'b1;
            state_n = SYNC;
            lcnt_n  = '0;
          end else begin
            shift_en = 1'b1;
            bit_val  = (hcnt >= TH_C);
            state_n  = LOW;
            lcnt_n   = ONE_C;
          end
        end else if (din_s && hcnt != {CW{1'b1}}) begin
          hcnt_n = hcnt + ONE_C;
        end
      end
      LOW: begin
        // Frame end wins; a coincident rise then opens bit 0 of a new frame.
        if (lcnt == RC_C) begin
          frame_end = 1'b1;
          err_n     = (bitcnt != 5'd0);
          if (rise) begin
            state_n = HIGH;
            hcnt_n  = ONE_C;
          end else begin
            state_n = IDLE;
          end
        end else if (rise) begin
          state_n = HIGH;
          hcnt_n  = ONE_C;
        end else if (lcnt != {CW{1'b1}}) begin
          lcnt_n = lcnt + ONE_C;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // Bit assembly, pixel completion one cycle after the 24th bit, frame
  // bookkeeping and registered outputs. An error also restarts pixel
  // numbering because decoding only resumes after a fresh latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt         <= '0;
      shreg          <= '0;
      idx            <= '0;
      px.pixel_data  <= '0;
      px.pixel_valid <= 1'b0;
      px.pixel_index <= '0;
      px.frame_done  <= 1'b0;
      px.pixel_count <= '0;
      px.err         <= 1'b0;
      px.busy        <= 1'b0;
    end else begin
      px.pixel_valid <= 1'b0;
      px.frame_done  <= frame_end;
      px.err         <= err_n;
      px.busy        <= (state_n == HIGH) || (state_n == LOW);
      if (shift_en) begin
        shreg <= MSB_FIRST ? {shreg[22:0], bit_val} : {bit_val, shreg[23:1]};
      end
      if (frame_end) begin
        px.pixel_count <= idx;
      end
      if (drop || frame_end) begin
        bitcnt <= '0;
        idx    <= '0;
      end else if (shift_en) begin
        bitcnt <= bitcnt + 5'd1;
      end else if (bitcnt == 5'd24) begin
        bitcnt         <= '0;
        px.pixel_valid <= 1'b1;
        px.pixel_data  <= shreg;
        px.pixel_index <= idx;
        if (idx != 8'hFF) begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812B-protocol receiver/decoder: samples a single-wire NeoPixel data line, classifies each bit by its high-pulse width, assembles 24-bit pixel words and detects the latch (reset) gap that ends a frame. It is the receive-side counterpart of the NeoPixel transmitter. It serves loopback verification of the LED driver on the board and accepts pixel streams from an external controller. It targets the same 12 MHz system clock, where one WS2812B tick is 4 clk and one bit period is 16 clk.

## Interface
- CLK_HZ, 12_000_000, system clock frequency; informational only, all timing is in clk cycles.
- MIN_HIGH, 2, shortest legal high pulse in clk cycles; shorter is a glitch.
- THRESH, 8, a high pulse of THRESH or more cycles decodes as '1'; shorter decodes as '0'.
- MAX_HIGH, 20, longest legal high pulse in clk cycles.
- RESET_CYCLES, 600, consecutive low cycles that end a frame (50 µs at 12 MHz).
- MSB_FIRST, 1, 1: the first wire bit lands in pixel_data[23]; 0: the first wire bit lands in pixel_data[0].
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  asynchronous serial data line.
- pixel_data  out  24  last completed pixel word; held until the next pixel completes.
- pixel_valid  out  1  one-cycle pulse when pixel_data updates.
- pixel_index  out  8  0-based position of the pixel in pixel_data within the current frame; saturates at 255.
- frame_done  out  1  one-cycle pulse when a latch gap ends a frame.
- pixel_count  out  8  number of complete pixels in the last finished frame; saturates at 255; held until the next frame_done.
- err  out  1  one-cycle pulse on a protocol error.
- busy  out  1  high while in state HIGH or LOW.

## Operation
- Input conditioning: din passes through a 2-flop synchronizer to give din_s, plus one more flop to give din_d. A rise is din_s & ~din_d. A fall is ~din_s & din_d.
- States:
  - SYNC: lcnt counts cycles with din_s=0 and clears whenever din_s=1. When lcnt reaches RESET_CYCLES, go to IDLE.
  - IDLE: on a rise, go to HIGH with hcnt=1.
  - HIGH: hcnt increments while din_s=1.
    - If hcnt exceeds MAX_HIGH while din is still high: pulse err, discard the partial pixel, go to SYNC.
    - On a fall with hcnt<MIN_HIGH: pulse err, discard the partial pixel, go to SYNC.
    - On any other fall: the decoded bit is (hcnt>=THRESH). Shift it in per MSB_FIRST and increment bitcnt. Go to LOW with lcnt=1.
  - LOW: on a rise, go to HIGH with hcnt=1. When lcnt reaches RESET_CYCLES, end the frame and go to IDLE.
- Pixel completion: when bitcnt reaches 24, load pixel_data from the shift register and pulse pixel_valid with the current pixel_index. Then clear bitcnt and increment pixel_index, saturating at 255.
- Frame end:
  - pixel_count ← number of completed pixels and frame_done pulses.
  - If bitcnt≠0, err also pulses in the same cycle and the partial bits are discarded.
  - pixel_index and bitcnt clear.
- Counters: hcnt and lcnt saturate and are sized $clog2(RESET_CYCLES+1) bits. pixel_index and pixel_count saturate at 255; they never wrap.
- Error recovery always goes through SYNC, so no decoding resumes until a full RESET_CYCLES low gap has been seen.
- Simultaneous events: if a rise occurs in the cycle lcnt reaches RESET_CYCLES, the frame end is processed first (frame_done), then HIGH is entered as bit 0 of pixel 0 of a new frame.

## Timing
- Reset values: pixel_data=0, pixel_valid=0, pixel_index=0, frame_done=0, pixel_count=0, err=0, busy=0, state=SYNC.
- rst_n assertion at any time, including mid-pixel, clears all state immediately. After rst_n deasserts, the block needs RESET_CYCLES low cycles before accepting data, so a stream already in progress is ignored until its next latch gap.
- Latency: pixel_valid is asserted exactly 3 clk after the first clk edge that samples din low at the end of the 24th bit (2 synchronizer stages + 1 registered output).
- frame_done is asserted 3 clk after the RESET_CYCLES-th consecutive low sample of din.
- err is asserted 3 clk after the offending sample.
- All outputs are registered. The pulse outputs are high for exactly one cycle.
- Pulse-width boundaries (at 12 MHz the transmitter's '0' is 4 clk high and its '1' is 12 clk high):
  - hcnt=MIN_HIGH-1 is an error; hcnt=MIN_HIGH is a '0'.
  - hcnt=THRESH-1 is a '0'; hcnt=THRESH is a '1'.
  - hcnt=MAX_HIGH is legal; hcnt=MAX_HIGH+1 is an error.

## Test plan
- Single pixel: reset, 600 low, then 0x1F003F MSB-first (4/12 clk highs, 16 clk period), then 600 low -> one pixel_valid with pixel_data=0x1F003F and pixel_index=0, 3 clk after the 24th fall; then frame_done with pixel_count=1 and no err.
- Full frame: 96 back-to-back pixels with pixel i = {16'h0, i[7:0]} -> 96 pixel_valid pulses, indices 0..95 with matching data, then frame_done with pixel_count=96.
- Pulse-width boundaries: bits with highs of 7, 8 and 20 clk -> decode as 0, 1, 1. A 1-clk high -> err, no pixel_valid, and data is ignored until a 600-clk low gap. A 21-clk high -> err while din is still high.
- Partial frame: 12 bits then 600 low -> frame_done and err in the same cycle, pixel_count=0, no pixel_valid; the next frame decodes normally from pixel_index 0.
- Mid-stream start and reset: release rst_n while din toggles mid-pixel -> no output until the first 600-low gap. Assert rst_n at bit 10 of pixel 3 -> all outputs return to 0 at once, and the next frame starts at pixel_index 0.
- Simultaneous event: a rise exactly when lcnt reaches 600 -> frame_done fires and the new pixel decodes correctly as pixel_index 0.
